id_ex_hazard_pipe: RTL and testbench
====================================

Name: id_ex_hazard_pipe

Overview:
- ID/EX pipeline register for the 5-stage RISCV core, with load-use hazard detection, bubble insertion and branch-flush handling.
- Captures decode-stage outputs each cycle and presents them to EX and to the forward controller (opcode, rs1, rs2, dest, wb mux selector).
- Stalls PC and IF/ID on a load-use hazard that forwarding cannot resolve.
- Keeps saturating performance counters for stall and flush events.

Parameters:
- DATA_W, 32, width of operand, immediate and PC fields
- CNT_W, 16, width of the saturating stall and flush counters

Ports:
- clk  input  1  core clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- id_valid_ip  input  1  decode stage holds a valid instruction
- id_instr_opcode_ip  input  7  decode opcode
- id_rs1_ip  input  5  decode rs1 index
- id_rs2_ip  input  5  decode rs2 index
- id_dest_ip  input  5  decode rd index
- id_rs1_data_ip  input  DATA_W  register file rs1 data
- id_rs2_data_ip  input  DATA_W  register file rs2 data
- id_imm_ip  input  DATA_W  decoded immediate
- id_pc_ip  input  DATA_W  instruction PC
- id_wb_mux_ip  input  write_back_mux_selector  writeback select of decode instruction
- ex_flush_ip  input  1  EX redirect (taken branch/jump); squash decode instruction
- mem_stall_ip  input  1  data memory not ready; freeze pipeline
- ex_valid_op  output  1  ID/EX valid
- ex_instr_opcode_op  output  7  ID/EX opcode
- ex_rs1_op, ex_rs2_op, ex_dest_op  output  5 each  ID/EX register indices
- ex_rs1_data_op, ex_rs2_data_op, ex_imm_op, ex_pc_op  output  DATA_W each  ID/EX data fields
- ex_wb_mux_op  output  write_back_mux_selector  ID/EX writeback select
- pc_stall_op  output  1  hold PC
- if_id_stall_op  output  1  hold IF/ID register
- stall_count_op  output  CNT_W  load-use stall cycles, saturating
- flush_count_op  output  CNT_W  flush cycles, saturating

Behaviour:
- Reset (reset=0, async): all ID/EX fields become a bubble: valid=0, opcode=0, indices=0, data=0, wb_mux=NO_WRITEBACK. Both counters=0, stall outputs=0.
- Bubble definition: valid=0, opcode=7'h00, dest=0, wb_mux=NO_WRITEBACK. Other fields are cleared to 0.
- rs1 is used by OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH and OPCODE_JALR.
- rs2 is used by OPCODE_OP, OPCODE_STORE and OPCODE_BRANCH.
- load_use (combinational from registered ID/EX state plus ID inputs) is true when all of the following hold:
  - ex_valid_op=1 and ex_instr_opcode_op==OPCODE_LOAD
  - ex_dest_op!=0 and id_valid_ip=1
  - ex_dest_op matches a used rs1 or a used rs2 of the decode instruction
- Update priority each rising edge, highest first:
  1. mem_stall_ip=1: hold all ID/EX fields; counters unchanged.
  2. ex_flush_ip=1: load bubble; flush_count +1 (saturating).
  3. load_use=1: load bubble; stall_count +1 (saturating).
  4. Otherwise load decode inputs. If id_valid_ip=0, load a bubble instead.
- pc_stall_op = if_id_stall_op = mem_stall_ip | (load_use & ~ex_flush_ip). These are combinational, same cycle. A flush never stalls, because the wrong-path decode instruction is discarded upstream.
- A load-use stall lasts exactly one cycle. After the bubble, the load sits in EX/MEM's successor and the decode instruction is served by WB forwarding. Two consecutive bubbles for the same hazard are a bug.
- With mem_stall_ip high, the registered state is frozen, so load_use may remain asserted. It is not counted until mem_stall_ip drops.
- Counters saturate at all-ones and do not wrap.
- Latency: decode inputs appear on ex_*_op one cycle after capture.
- Reset asserted mid-stall returns immediately to the reset state. The next edge after deassertion loads decode inputs normally.

Test Plan:
- Reset: assert reset=0 with random inputs → all ex_*_op bubble, ex_wb_mux_op=NO_WRITEBACK, counters 0. Release reset, then feed ADD x3,x1,x2 → next cycle ex_dest_op=3, ex_valid_op=1.
- Load-use on rs2: LW x5 in ID/EX, decode ADD x6,x1,x5 → pc_stall_op=1 for 1 cycle; bubble enters ID/EX; stall_count_op=1. Next cycle the ADD is captured and stall=0.
- No false hazard:
  - LW x5 followed by ADDI x6,x0,5 (rs2 field=5 but unused) → no stall.
  - LW x0 followed by ADD x1,x0,x0 → no stall.
- Flush beats hazard: LW x5 in ID/EX, decode ADD x6,x5,x5, ex_flush_ip=1 → pc_stall_op=0; bubble loaded; flush_count_op=1, stall_count_op=0.
- Memory stall: mem_stall_ip=1 for 3 cycles with changing decode inputs → ex_*_op unchanged, pc_stall_op=1. Release → normal capture resumes.
- Saturation: force 2^CNT_W+3 load-use stalls → stall_count_op=16'hFFFF, with no wrap.

Source files
------------

// File: rtl/id_ex_hazard_pipe.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion,
// branch-flush squashing and saturating stall/flush event counters.

typedef enum logic [1:0] {
  NO_WRITEBACK = 2'd0,
  WB_ALU       = 2'd1,
  WB_MEM       = 2'd2,
  WB_PC4       = 2'd3
} write_back_mux_selector;

localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
localparam logic [6:0] OPCODE_OPIMM  = 7'b0010011;
localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
localparam logic [6:0] OPCODE_OP     = 7'b0110011;
localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
localparam logic [6:0] OPCODE_JAL    = 7'b1101111;

module id_ex_hazard_pipe #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   id_valid_ip,
  input  logic [6:0]             id_instr_opcode_ip,
  input  logic [4:0]             id_rs1_ip,
  input  logic [4:0]             id_rs2_ip,
  input  logic [4:0]             id_dest_ip,
  input  logic [DATA_W-1:0]      id_rs1_data_ip,
  input  logic [DATA_W-1:0]      id_rs2_data_ip,
  input  logic [DATA_W-1:0]      id_imm_ip,
  input  logic [DATA_W-1:0]      id_pc_ip,
  input  write_back_mux_selector id_wb_mux_ip,
  input  logic                   ex_flush_ip,
  input  logic                   mem_stall_ip,
  output logic                   ex_valid_op,
  output logic [6:0]             ex_instr_opcode_op,
  output logic [4:0]             ex_rs1_op,
  output logic [4:0]             ex_rs2_op,
  output logic [4:0]             ex_dest_op,
  output logic [DATA_W-1:0]      ex_rs1_data_op,
  output logic [DATA_W-1:0]      ex_rs2_data_op,
  output logic [DATA_W-1:0]      ex_imm_op,
  output logic [DATA_W-1:0]      ex_pc_op,
  output write_back_mux_selector ex_wb_mux_op,
  output logic                   pc_stall_op,
  output logic                   if_id_stall_op,
  output logic [CNT_W-1:0]       stall_count_op,
  output logic [CNT_W-1:0]       flush_count_op
);

  typedef struct packed {
    logic                   valid;
    logic [6:0]             opcode;
    logic [4:0]             rs1;
    logic [4:0]             rs2;
    logic [4:0]             dest;
    logic [DATA_W-1:0]      rs1_data;
    logic [DATA_W-1:0]      rs2_data;
    logic [DATA_W-1:0]      imm;
    logic [DATA_W-1:0]      pc;
    write_back_mux_selector wb_mux;
  } stage_t;

  function automatic stage_t bubble_f();
    stage_t b;
    b        = '0;
    b.wb_mux = NO_WRITEBACK;
    return b;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  stage_t           stage_reg, stage_next, decode;
  logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
  logic [CNT_W-1:0] flush_cnt_reg, flush_cnt_next;
  logic             rs1_used, rs2_used, load_use;

  always_comb begin
    decode          = bubble_f();
    decode.valid    = 1'b1;
    decode.opcode   = id_instr_opcode_ip;
    decode.rs1      = id_rs1_ip;
    decode.rs2      = id_rs2_ip;
    decode.dest     = id_dest_ip;
    decode.rs1_data = id_rs1_data_ip;
    decode.rs2_data = id_rs2_data_ip;
    decode.imm      = id_imm_ip;
    decode.pc       = id_pc_ip;
    decode.wb_mux   = id_wb_mux_ip;
  end

  // Only register fields the decode opcode actually reads can create a hazard.
  always_comb begin
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (id_instr_opcode_ip)
      OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
      end
      OPCODE_OPIMM, OPCODE_LOAD, OPCODE_JALR: rs1_used = 1'b1;
      default: ;
    endcase
  end

  assign load_use = stage_reg.valid && (stage_reg.opcode == OPCODE_LOAD) &&
                    (stage_reg.dest != 5'd0) && id_valid_ip &&
                    ((rs1_used && (id_rs1_ip == stage_reg.dest)) ||
                     (rs2_used && (id_rs2_ip == stage_reg.dest)));

  // A flush discards the decode instruction upstream, so it never stalls.
  assign pc_stall_op    = mem_stall_ip | (load_use & ~ex_flush_ip);
  assign if_id_stall_op = pc_stall_op;

  always_comb begin
    stage_next     = stage_reg;
    stall_cnt_next = stall_cnt_reg;
    flush_cnt_next = flush_cnt_reg;
    if (mem_stall_ip) begin
      stage_next = stage_reg;
    end else if (ex_flush_ip) begin
      stage_next     = bubble_f();
      flush_cnt_next = sat_inc(flush_cnt_reg);
    end else if (load_use) begin
      stage_next     = bubble_f();
      stall_cnt_next = sat_inc(stall_cnt_reg);
    end else if (id_valid_ip) begin
      stage_next = decode;
    end else begin
      stage_next = bubble_f();
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_reg     <= bubble_f();
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      stage_reg     <= stage_next;
      stall_cnt_reg <= stall_cnt_next;
      flush_cnt_reg <= flush_cnt_next;
    end
  end

  assign ex_valid_op        = stage_reg.valid;
  assign ex_instr_opcode_op = stage_reg.opcode;
  assign ex_rs1_op          = stage_reg.rs1;
  assign ex_rs2_op          = stage_reg.rs2;
  assign ex_dest_op         = stage_reg.dest;
  assign ex_rs1_data_op     = stage_reg.rs1_data;
  assign ex_rs2_data_op     = stage_reg.rs2_data;
  assign ex_imm_op          = stage_reg.imm;
  assign ex_pc_op           = stage_reg.pc;
  assign ex_wb_mux_op       = stage_reg.wb_mux;
  assign stall_count_op     = stall_cnt_reg;
  assign flush_count_op     = flush_cnt_reg;

endmodule

// File: tb/tb_id_ex_hazard_pipe.sv
// Randomized and directed bench for id_ex_hazard_pipe against a record-level
// reference model of the ID/EX stage and its event counters.

module tb_id_ex_hazard_pipe;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam bit [6:0] RS1_USERS [6] = '{OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD,
                                         OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR};
  localparam bit [6:0] RS2_USERS [3] = '{OPCODE_OP, OPCODE_STORE, OPCODE_BRANCH};
  localparam bit [6:0] OP_POOL   [9] = '{OPCODE_OP, OPCODE_OPIMM, OPCODE_LOAD,
                                         OPCODE_STORE, OPCODE_BRANCH, OPCODE_JALR,
                                         OPCODE_JAL, OPCODE_LUI, OPCODE_AUIPC};

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   id_valid;
  logic [6:0]             id_op;
  logic [4:0]             id_rs1, id_rs2, id_dest;
  logic [DATA_W-1:0]      id_d1, id_d2, id_imm, id_pc;
  write_back_mux_selector id_wb;
  logic                   flush, mem_stall;
  logic                   ex_valid;
  logic [6:0]             ex_op;
  logic [4:0]             ex_rs1, ex_rs2, ex_dest;
  logic [DATA_W-1:0]      ex_d1, ex_d2, ex_imm, ex_pc;
  write_back_mux_selector ex_wb;
  logic                   pc_stall, if_id_stall;
  logic [CNT_W-1:0]       stall_count, flush_count;

  id_ex_hazard_pipe #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid_ip(id_valid), .id_instr_opcode_ip(id_op),
    .id_rs1_ip(id_rs1), .id_rs2_ip(id_rs2), .id_dest_ip(id_dest),
    .id_rs1_data_ip(id_d1), .id_rs2_data_ip(id_d2),
    .id_imm_ip(id_imm), .id_pc_ip(id_pc), .id_wb_mux_ip(id_wb),
    .ex_flush_ip(flush), .mem_stall_ip(mem_stall),
    .ex_valid_op(ex_valid), .ex_instr_opcode_op(ex_op),
    .ex_rs1_op(ex_rs1), .ex_rs2_op(ex_rs2), .ex_dest_op(ex_dest),
    .ex_rs1_data_op(ex_d1), .ex_rs2_data_op(ex_d2),
    .ex_imm_op(ex_imm), .ex_pc_op(ex_pc), .ex_wb_mux_op(ex_wb),
    .pc_stall_op(pc_stall), .if_id_stall_op(if_id_stall),
    .stall_count_op(stall_count), .flush_count_op(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        valid;
    bit [6:0]  op;
    bit [4:0]  rs1, rs2, dest;
    bit [31:0] d1, d2, imm, pc;
    bit [1:0]  wb;
  } rec_t;

  rec_t m_ex;
  int   m_stalls, m_flushes;
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp)
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    else
      passes++;
  endtask

  function automatic rec_t bubble_rec();
    rec_t r;
    r       = '{default: 0};
    r.wb    = NO_WRITEBACK;
    return r;
  endfunction

  function automatic bit model_hazard();
    bit hit = 1'b0;
    if (!(m_ex.valid && m_ex.op == OPCODE_LOAD && m_ex.dest != 0 && id_valid))
      return 1'b0;
    for (int i = 0; i < 6; i++)
      if (id_op == RS1_USERS[i] && id_rs1 == m_ex.dest) hit = 1'b1;
    for (int i = 0; i < 3; i++)
      if (id_op == RS2_USERS[i] && id_rs2 == m_ex.dest) hit = 1'b1;
    return hit;
  endfunction

  function automatic int clamp(input int n);
    return (n > CNT_MAX) ? CNT_MAX : n;
  endfunction

  task automatic check_state();
    check("ex_valid",  ex_valid, m_ex.valid);
    check("ex_op",     ex_op,    m_ex.op);
    check("ex_rs1",    ex_rs1,   m_ex.rs1);
    check("ex_rs2",    ex_rs2,   m_ex.rs2);
    check("ex_dest",   ex_dest,  m_ex.dest);
    check("ex_d1",     ex_d1,    m_ex.d1);
    check("ex_d2",     ex_d2,    m_ex.d2);
    check("ex_imm",    ex_imm,   m_ex.imm);
    check("ex_pc",     ex_pc,    m_ex.pc);
    check("ex_wb",     ex_wb,    m_ex.wb);
    check("stall_cnt", stall_count, clamp(m_stalls));
    check("flush_cnt", flush_count, clamp(m_flushes));
  endtask

  task automatic model_reset();
    m_ex      = bubble_rec();
    m_stalls  = 0;
    m_flushes = 0;
  endtask

  task automatic set_id(input bit v, input bit [6:0] op, input bit [4:0] r1,
                        input bit [4:0] r2, input bit [4:0] rd, input bit [1:0] wb);
    id_valid = v;
    id_op    = op;
    id_rs1   = r1;
    id_rs2   = r2;
    id_dest  = rd;
    id_d1    = $urandom;
    id_d2    = $urandom;
    id_imm   = $urandom;
    id_pc    = $urandom;
    id_wb    = write_back_mux_selector'(wb);
  endtask

  // Entered just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic run_cycle();
    bit   hz;
    rec_t nxt;
    #1;
    hz = model_hazard();
    check("pc_stall",    pc_stall,    mem_stall | (hz & ~flush));
    check("if_id_stall", if_id_stall, mem_stall | (hz & ~flush));
    nxt = m_ex;
    if (mem_stall) begin
      nxt = m_ex;
    end else if (flush) begin
      nxt = bubble_rec();
      m_flushes++;
    end else if (hz) begin
      nxt = bubble_rec();
      m_stalls++;
    end else if (id_valid) begin
      nxt = '{1'b1, id_op, id_rs1, id_rs2, id_dest, id_d1, id_d2, id_imm, id_pc, id_wb};
    end else begin
      nxt = bubble_rec();
    end
    @(posedge clk);
    #1;
    m_ex = nxt;
    check_state();
    $display("cycle t=%0t valid=%0d op=%02h rs1=%0d rs2=%0d rd=%0d flush=%0d mstall=%0d -> ex_valid=%0d ex_rd=%0d stalls=%0d flushes=%0d",
             $time, id_valid, id_op, id_rs1, id_rs2, id_dest, flush, mem_stall,
             ex_valid, ex_dest, stall_count, flush_count);
    @(negedge clk);
  endtask

  initial begin
    reset     = 1'b0;
    flush     = 1'b0;
    mem_stall = 1'b0;
    set_id(1'b1, OPCODE_LOAD, 5'd3, 5'd4, 5'd3, 2'd2);
    model_reset();
    repeat (2) @(negedge clk);
    check_state();
    check("rst_stall", pc_stall, 1'b0);
    reset = 1'b1;

    // ADD x3,x1,x2
    set_id(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd3, 2'd1);
    run_cycle();
    check("add_dest",  ex_dest,  5'd3);
    check("add_valid", ex_valid, 1'b1);

    // LW x5 then ADD x6,x1,x5: one bubble, then the ADD is captured
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 2'd2);
    run_cycle();
    set_id(1'b1, OPCODE_OP, 5'd1, 5'd5, 5'd6, 2'd1);
    run_cycle();
    check("lu_bubble",    ex_valid,    1'b0);
    check("lu_stall_cnt", stall_count, 8'd1);
    run_cycle();
    check("lu_resume_dest", ex_dest,  5'd6);
    check("lu_once",        pc_stall, 1'b0);

    // LW x5 then ADDI x6,x0,5: rs2 field unused
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 2'd2);
    run_cycle();
    set_id(1'b1, OPCODE_OPIMM, 5'd0, 5'd5, 5'd6, 2'd1);
    run_cycle();
    check("addi_no_stall", stall_count, 8'd1);
    check("addi_captured", ex_dest, 5'd6);

    // LW x0 then ADD x1,x0,x0
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd0, 2'd2);
    run_cycle();
    set_id(1'b1, OPCODE_OP, 5'd0, 5'd0, 5'd1, 2'd1);
    run_cycle();
    check("x0_no_stall", stall_count, 8'd1);

    // Flush beats load-use
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 2'd2);
    run_cycle();
    set_id(1'b1, OPCODE_OP, 5'd5, 5'd5, 5'd6, 2'd1);
    flush = 1'b1;
    run_cycle();
    flush = 1'b0;
    check("flush_cnt1",  flush_count, 8'd1);
    check("flush_nostl", stall_count, 8'd1);
    check("flush_bub",   ex_valid,    1'b0);

    // Memory stall freezes the stage for three cycles
    set_id(1'b1, OPCODE_LOAD, 5'd2, 5'd0, 5'd7, 2'd2);
    run_cycle();
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1'b1, OP_POOL[$urandom_range(0, 8)], 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
      run_cycle();
    end
    check("mstall_hold", ex_dest, 5'd7);
    mem_stall = 1'b0;
    set_id(1'b1, OPCODE_OP, 5'd1, 5'd2, 5'd8, 2'd1);
    run_cycle();
    check("mstall_resume", ex_dest, 5'd8);

    // Reset asserted while a load-use stall is pending
    set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 2'd2);
    run_cycle();
    set_id(1'b1, OPCODE_OP, 5'd5, 5'd1, 5'd6, 2'd1);
    #2;
    check("pre_rst_stall", pc_stall, 1'b1);
    reset = 1'b0;
    #1;
    model_reset();
    check_state();
    check("rst_stall_clr", pc_stall, 1'b0);
    reset = 1'b1;
    run_cycle();
    check("post_rst_dest", ex_dest, 5'd6);

    // Random traffic over a small register set to provoke hazards
    for (int n = 0; n < 400; n++) begin
      set_id($urandom_range(0, 99) < 85, OP_POOL[$urandom_range(0, 8)],
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      flush     = $urandom_range(0, 99) < 10;
      mem_stall = $urandom_range(0, 99) < 15;
      run_cycle();
    end
    flush     = 1'b0;
    mem_stall = 1'b0;

    // Counter saturation: more than 2^CNT_W events of each kind
    for (int n = 0; n < CNT_MAX + 4; n++) begin
      set_id(1'b1, OPCODE_LOAD, 5'd1, 5'd0, 5'd5, 2'd2);
      run_cycle();
      set_id(1'b1, OPCODE_OP, 5'd1, 5'd5, 5'd6, 2'd1);
      run_cycle();
    end
    check("stall_sat", stall_count, 8'hFF);
    flush = 1'b1;
    for (int n = 0; n < CNT_MAX + 4; n++) run_cycle();
    flush = 1'b0;
    check("flush_sat", flush_count, 8'hFF);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
